// File: rtl/muldiv_unit.sv
// Purpose: iterative 32-bit RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: fixed; start accepted at edge E0, done/wen high in the cycle between E32 and E33.
// Backpressure: none; start is ignored while busy, so the issuer must wait for busy to drop.
module muldiv_unit (
    input  logic        clk,
    input  logic        res_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        wen,
    output logic [4:0]  rc,
    output logic [31:0] dc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic [2:0]  f3_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    // hi/lo hold {partial product} for multiply and {remainder, quotient} for divide
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res_q;

    // Which operand is interpreted as signed for a given op.
    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // Magnitudes of the incoming operands, used to seed the datapath at acceptance
    logic        in_a_neg;
    logic        in_b_neg;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;

    assign in_a_neg = op_a[31] & a_is_signed(funct3);
    assign in_b_neg = op_b[31] & b_is_signed(funct3);
    assign in_mag_a = in_a_neg ? (32'd0 - op_a) : op_a;
    assign in_mag_b = in_b_neg ? (32'd0 - op_b) : op_b;

    // Magnitudes of the latched operands, used during the iterations and the sign fix-up
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign a_neg = a_q[31] & a_is_signed(f3_q);
    assign b_neg = b_q[31] & b_is_signed(f3_q);
    assign mag_a = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b = b_neg ? (32'd0 - b_q) : b_q;

    // One iteration of both algorithms; the op selects which one is committed
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;

    assign mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mag_a : 32'd0)};
    assign div_shift = {hi, lo[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    assign div_ok    = ~div_diff[33];

    assign hi_nxt = f3_q[2] ? (div_ok ? div_diff[31:0] : div_shift[31:0]) : mul_sum[32:1];
    assign lo_nxt = f3_q[2] ? {lo[30:0], div_ok} : {mul_sum[0], lo[31:1]};

    // Sign fix-up and special cases, applied to the values of the final iteration
    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] mul_res;
    logic [31:0] quot;
    logic [31:0] remv;
    logic [31:0] res_nxt;

    assign prod    = {hi_nxt, lo_nxt};
    assign prod_s  = (a_neg ^ b_neg) ? (64'd0 - prod) : prod;
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    // divide by zero: all-ones quotient, dividend as remainder; overflow falls out naturally
    assign quot    = (b_q == 32'd0) ? 32'hFFFF_FFFF
                   : ((a_neg ^ b_neg) ? (32'd0 - lo_nxt) : lo_nxt);
    assign remv    = (b_q == 32'd0) ? a_q : (a_neg ? (32'd0 - hi_nxt) : hi_nxt);
    assign res_nxt = f3_q[2] ? (f3_q[1] ? remv : quot) : mul_res;

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, 32 iterations in RUN, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration counter and datapath registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt   <= 5'd0;
            f3_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rd_q  <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            res_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= 5'd0;
                        f3_q <= funct3;
                        a_q  <= op_a;
                        b_q  <= op_b;
                        rd_q <= rd;
                        hi   <= 32'd0;
                        lo   <= funct3[2] ? in_mag_a : in_mag_b;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        res_q <= res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign wen  = (state == DONE) && (rd_q != 5'd0);
    assign rc   = (state == DONE) ? rd_q : 5'd0;
    assign dc   = (state == DONE) ? res_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency: expects done exactly 32 edges after acceptance, busy low one cycle later.
// Backpressure: drives extra start pulses while busy and expects them to be ignored.
module tb_muldiv_unit;

    logic        clk;
    logic        res_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        wen;
    logic [4:0]  rc;
    logic [31:0] dc;

    int tests;
    int errors;

    muldiv_unit dut (
        .clk    (clk),
        .res_n  (res_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .wen    (wen),
        .rc     (rc),
        .dc     (dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit / integer arithmetic following the RV32M rules
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin x = {32'd0, a};        y = {32'd0, b};        p = x * y; return p[31:0];  end
            3'd1: begin x = {{32{a[31]}}, a};  y = {{32{b[31]}}, b};  p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a};  y = {32'd0, b};        p = x * y; return p[63:32]; end
            3'd3: begin x = {32'd0, a};        y = {32'd0, b};        p = x * y; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and check the full response timeline; start is re-pulsed while
    // busy (RUN cycle 10 and the last RUN/DONE cycles) and inputs are scrambled after
    // acceptance, none of which may disturb the result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
        logic [31:0] exp;
        int          ndone;
        logic        early;
        exp   = ref_res(f, a, b);
        ndone = 0;
        early = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd     = r;
        @(posedge clk); #1;                    // E0 has accepted the op
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd     = 5'($urandom);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 1) chk("busy_in_run", {31'd0, busy}, 32'd1);
            if (k < 32 && (done || wen)) early = 1'b1;
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            if (k == 31) start = 1'b1;
            if (k == 32) begin
                chk("done", {31'd0, done}, 32'd1);
                chk("busy_done", {31'd0, busy}, 32'd1);
                chk("wen", {31'd0, wen}, {31'd0, (r != 5'd0)});
                chk("rc", {27'd0, rc}, {27'd0, r});
                chk("dc", dc, exp);
            end
            if (k == 33) begin
                start = 1'b0;
                chk("busy_after", {31'd0, busy}, 32'd0);
                chk("dc_after", dc, 32'd0);
                chk("rc_after", {27'd0, rc}, 32'd0);
            end
        end
        chk("early_done", {31'd0, early}, 32'd0);
        chk("done_pulses", ndone, 32'd1);
    endtask

    task automatic reset_mid_run();
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        rd     = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 res_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_rc", {27'd0, rc}, 32'd0);
        chk("rst_dc", dc, 32'd0);
        repeat (2) @(posedge clk);
        #3 res_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || wen || busy) seen = 1'b1;
        end
        chk("rst_abort", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        res_n  = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        rd     = 5'd0;
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_wen", {31'd0, wen}, 32'd0);
        chk("reset_rc", {27'd0, rc}, 32'd0);
        chk("reset_dc", dc, 32'd0);
        repeat (2) @(posedge clk);
        #3 res_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd5, 32'd100, 32'd0, 5'd7);
        run_op(3'd7, 32'd100, 32'd0, 5'd8);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd10);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(3'd0, 32'd123, 32'd456, 5'd0);

        reset_mid_run();
        run_op(3'd4, 32'd1000, 32'd7, 5'd9);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 res_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand (register-file read port a).
REQ-007 op_b  input  32  rs2 operand (register-file read port b).
REQ-008 rd  input  5  destination register index.
REQ-009 busy  output  1  high while an operation is in flight, including the DONE cycle.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 wen  output  1  register-file write enable.
REQ-012 rc  output  5  register-file write index.
REQ-013 dc  output  32  register-file write data.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at an edge SHALL latch funct3, op_a, op_b and rd, clear the iteration counter, and enter RUN; start=0 keeps IDLE.
REQ-016 RUN SHALL perform exactly one iteration per edge (shift-add for MUL*, restoring shift-subtract for DIV*/REM*); after the 32nd iteration edge it SHALL enter DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; start is not sampled in DONE, so the earliest next acceptance is the first IDLE cycle.
REQ-018 Latency SHALL be fixed: start accepted at edge E0 -> done/wen high in the cycle between E32 and E33, for every op including the special cases below.
REQ-019 start while busy SHALL be ignored; latched operands SHALL NOT change during RUN/DONE.
REQ-020 All outputs SHALL be driven from registers or state only; there is no combinational path from start/op_a/op_b to the outputs.
REQ-021 done SHALL be 1 only in DONE; wen SHALL equal done AND (rd != 0); rc SHALL equal the latched rd in DONE and 0 otherwise.
REQ-022 dc SHALL hold the result in DONE and 0 otherwise.
REQ-023 Signed ops SHALL run on magnitudes, with the sign applied after the final iteration: MULH signed x signed, MULHSU signed op_a x unsigned op_b, MULHU unsigned x unsigned.
REQ-024 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-025 DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-026 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV, DIVU) and remainder = op_a (REM, REMU).
REQ-027 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF) SHALL return DIV 0x80000000 and REM 0x00000000.
REQ-028 Latching rd is mandatory: rd may change after acceptance without affecting rc.

Reset
REQ-029 res_n=0 SHALL immediately, asynchronously, force IDLE and clear the counter, latched operands and all outputs (busy, done, wen, rc, dc = 0).
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no write; after release the block accepts start normally.

Verification
REQ-031 MUL, op_a=7, op_b=0xFFFFFFFD, rd=5 -> in cycle 33 after acceptance: done=1, wen=1, rc=5, dc=0xFFFFFFEB; busy=0 next cycle.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> dc=0xFFFFFFFE; MULH with the same operands -> dc=0x00000000.
REQ-033 DIV -7/2 -> dc=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 0x00000064; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
REQ-034 Second start pulsed at cycle 10 of a run -> ignored, exactly one done pulse; rd=0 -> done=1, wen=0.
REQ-035 res_n low at RUN cycle 15 -> all outputs 0 immediately, no done/wen pulse; new op after release completes with correct result at full latency.
